// File: rtl/frame_pkt_pkg.sv
// Shared frame/packet constants for the DDR frame reader and writer:
// MAC header fields, buffer base addresses, segment tags and reader FSM states.
package frame_pkt_pkg;

  localparam logic [47:0] DST_MAC   = 48'hadadadadadad;
  localparam logic [47:0] SRC_MAC   = 48'hacacacacacac;
  localparam logic [15:0] DATA_TYPE = 16'h9000;

  localparam logic [31:0] BASE_EVEN = 32'h2BC00000;
  localparam logic [31:0] BASE_ODD  = 32'h2BE00000;

  localparam logic [1:0] TAG_HEAD = 2'b10;
  localparam logic [1:0] TAG_MID  = 2'b00;
  localparam logic [1:0] TAG_TAIL = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_AR   = 3'd2,
    ST_R    = 3'd3,
    ST_EMIT = 3'd4,
    ST_DONE = 3'd5
  } rd_state_e;

  function automatic logic [511:0] make_header(input logic [15:0] pkt_idx,
                                               input logic flag);
    logic [511:0] h;
    h            = '0;
    h[511:464]   = DST_MAC;
    h[463:416]   = SRC_MAC;
    h[415:400]   = DATA_TYPE;
    h[399:384]   = pkt_idx;
    h[383]       = flag;
    return h;
  endfunction

endpackage

// File: rtl/frame_pkt_reader.sv
// Reads one frame from DDR over AXI4 (16-beat bursts) and emits head + payload segments.
// FRAME_PKT_READER_ERR_ABORT_EN: when defined, the first read error ends the frame early.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid, once raised, holds its payload stable until that edge.
module frame_pkt_reader
  import frame_pkt_pkg::*;
#(
  parameter int FRAME_BURSTS = 9600,
  parameter int PKT_BURSTS   = 16
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         ddr_read_start_valid,
  output logic         ddr_read_start_ready,
  input  logic         odd_even_flag,
  output logic         ddr_read_finish,
  output logic         ddr_read_finish_valid,
  input  logic         ddr_read_finish_ready,
  output logic [519:0] pktout_data,
  output logic         pktout_en,
  input  logic         pktout_alf,
  output logic [0:0]   M_AXI_ARID,
  output logic [31:0]  M_AXI_ARADDR,
  output logic [7:0]   M_AXI_ARLEN,
  output logic [2:0]   M_AXI_ARSIZE,
  output logic [1:0]   M_AXI_ARBURST,
  output logic         M_AXI_ARLOCK,
  output logic [3:0]   M_AXI_ARCACHE,
  output logic [2:0]   M_AXI_ARPROT,
  output logic [3:0]   M_AXI_ARQOS,
  output logic [0:0]   M_AXI_ARUSER,
  output logic         M_AXI_ARVALID,
  input  logic         M_AXI_ARREADY,
  input  logic [0:0]   M_AXI_RID,
  input  logic [31:0]  M_AXI_RDATA,
  input  logic [1:0]   M_AXI_RRESP,
  input  logic         M_AXI_RLAST,
  input  logic [0:0]   M_AXI_RUSER,
  input  logic         M_AXI_RVALID,
  output logic         M_AXI_RREADY,
  output rd_state_e    dbg_state_o
);

  localparam int             NUM_PKTS   = FRAME_BURSTS / PKT_BURSTS;
  localparam int             BW         = (PKT_BURSTS > 1) ? $clog2(PKT_BURSTS) : 1;
  localparam logic [BW-1:0]  LAST_BURST = BW'(PKT_BURSTS - 1);
  localparam logic [15:0]    LAST_PKT   = 16'(NUM_PKTS - 1);

  rd_state_e      state_q;
  logic [31:0]    addr_q;
  logic [BW-1:0]  burst_q;
  logic [15:0]    pkt_q;
  logic [3:0]     beat_q;
  logic           err_q;
  logic           flag_q;
  logic [511:0]   seg_q;
  logic [519:0]   pkt_data_q;
  logic           pkt_en_q;
  logic           arvalid_q;
  logic           rready_q;
  logic           start_ready_q;
  logic           fin_valid_q;
  logic           fin_q;

  logic [511:0]   seg_d;
  logic           err_d;
  logic           last_beat;
  logic           beat_err;
  logic           tail_d;
  logic           abort;
  logic           unused_ok;

  assign M_AXI_ARID    = 1'b0;
  assign M_AXI_ARLEN   = 8'd15;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = 1'b1;

  assign M_AXI_ARADDR          = addr_q;
  assign M_AXI_ARVALID         = arvalid_q;
  assign M_AXI_RREADY          = rready_q;
  assign pktout_data           = pkt_data_q;
  assign pktout_en             = pkt_en_q;
  assign ddr_read_start_ready  = start_ready_q;
  assign ddr_read_finish_valid = fin_valid_q;
  assign ddr_read_finish       = fin_q;
  assign dbg_state_o           = state_q;
  assign unused_ok             = ^{M_AXI_RID, M_AXI_RUSER};

  always_comb begin
    seg_d                        = seg_q;
    seg_d[{beat_q, 5'b0} +: 32]  = M_AXI_RDATA;
    last_beat = M_AXI_RLAST | (beat_q == 4'd15);
    // RLAST must coincide exactly with beat 15; either mismatch is an error.
    beat_err  = (M_AXI_RRESP != 2'b00) | (M_AXI_RLAST != (beat_q == 4'd15));
    err_d     = err_q | (M_AXI_RVALID & beat_err);
`ifdef FRAME_PKT_READER_ERR_ABORT_EN
    tail_d    = (burst_q == LAST_BURST) | err_d;
    abort     = err_q;
`else
    tail_d    = (burst_q == LAST_BURST);
    abort     = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      burst_q       <= '0;
      pkt_q         <= '0;
      beat_q        <= '0;
      err_q         <= 1'b0;
      flag_q        <= 1'b0;
      seg_q         <= '0;
      pkt_data_q    <= '0;
      pkt_en_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      start_ready_q <= 1'b0;
      fin_valid_q   <= 1'b0;
      fin_q         <= 1'b0;
    end else begin
      pkt_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          start_ready_q <= 1'b1;
          if (start_ready_q && ddr_read_start_valid) begin
            start_ready_q <= 1'b0;
            addr_q        <= odd_even_flag ? BASE_ODD : BASE_EVEN;
            flag_q        <= odd_even_flag;
            burst_q       <= '0;
            pkt_q         <= '0;
            err_q         <= 1'b0;
            state_q       <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!pktout_alf) begin
            pkt_en_q   <= 1'b1;
            pkt_data_q <= {TAG_HEAD, 6'b0, make_header(pkt_q, flag_q)};
            arvalid_q  <= 1'b1;
            state_q    <= ST_AR;
          end
        end
        ST_AR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (M_AXI_RVALID) begin
            seg_q  <= seg_d;
            beat_q <= beat_q + 4'd1;
            err_q  <= err_d;
            if (last_beat) begin
              rready_q   <= 1'b0;
              pkt_en_q   <= 1'b1;
              pkt_data_q <= {(tail_d ? TAG_TAIL : TAG_MID), 6'b0, seg_d};
              state_q    <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          addr_q <= addr_q + 32'd64;
          if (abort) begin
            fin_valid_q <= 1'b1;
            fin_q       <= 1'b0;
            state_q     <= ST_DONE;
          end else if (burst_q != LAST_BURST) begin
            burst_q   <= burst_q + 1'b1;
            arvalid_q <= 1'b1;
            state_q   <= ST_AR;
          end else if (pkt_q != LAST_PKT) begin
            pkt_q   <= pkt_q + 16'd1;
            burst_q <= '0;
            state_q <= ST_HDR;
          end else begin
            fin_valid_q <= 1'b1;
            fin_q       <= ~err_q;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ddr_read_finish_ready) begin
            fin_valid_q <= 1'b0;
            fin_q       <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_pkt_reader.sv
// Scoreboard bench for frame_pkt_reader on a reduced frame (6 packets x 16 bursts)
// with an AXI slave/memory model and optional ready/valid stalls.
module tb_frame_pkt_reader;
  import frame_pkt_pkg::*;

  localparam int FB = 96;
  localparam int PB = 16;
  localparam int NP = FB / PB;

  logic         clk = 1'b0;
  logic         areset;
  logic         start_valid, start_ready, flag;
  logic         finish, finish_valid, finish_ready;
  logic [519:0] pktout_data;
  logic         pktout_en, pktout_alf;
  logic [0:0]   arid, aruser;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst;
  logic         arlock;
  logic [3:0]   arcache, arqos;
  logic         arvalid, arready;
  logic [0:0]   rid, ruser;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;
  rd_state_e    dbg_state;

  logic [519:0] exp_q[$];
  logic [31:0]  exp_ar_q[$];
  int           checks = 0;
  int           passes = 0;
  int           stall_en = 0;
  int           err_burst = -1;
  int           ar_cnt = 0;

  always #5 clk = ~clk;

  frame_pkt_reader #(.FRAME_BURSTS(FB), .PKT_BURSTS(PB)) dut (
    .clk(clk), .areset(areset),
    .ddr_read_start_valid(start_valid), .ddr_read_start_ready(start_ready),
    .odd_even_flag(flag),
    .ddr_read_finish(finish), .ddr_read_finish_valid(finish_valid),
    .ddr_read_finish_ready(finish_ready),
    .pktout_data(pktout_data), .pktout_en(pktout_en), .pktout_alf(pktout_alf),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock),
    .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
    .M_AXI_ARUSER(aruser), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RLAST(rlast), .M_AXI_RUSER(ruser), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready), .dbg_state_o(dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
  endfunction

  task automatic check(input bit ok, input string name,
                       input logic [519:0] act, input logic [519:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor for emitted segments.
  initial begin
    logic [519:0] e;
    forever begin
      @(negedge clk);
      if (!areset && pktout_en) begin
        if (exp_q.size() == 0) check(1'b0, "pkt_unexpected", pktout_data, '0);
        else begin
          e = exp_q.pop_front();
          check(pktout_data === e, "pkt_data", pktout_data, e);
        end
      end
    end
  end

  // AXI read slave over a computed memory; also checks each accepted ARADDR.
  initial begin
    logic        busy = 1'b0;
    logic        ar_hs, r_hs;
    logic [31:0] sa, cur_addr, e;
    int          beat = 0;
    int          cur_burst = 0;
    cur_addr = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
    rid = 1'b0; ruser = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      sa    = araddr;
      if (ar_hs && !areset) begin
        if (exp_ar_q.size() == 0) check(1'b0, "ar_unexpected", 520'(sa), '0);
        else begin
          e = exp_ar_q.pop_front();
          check(sa === e, "araddr", 520'(sa), 520'(e));
        end
      end
      @(posedge clk);
      #1;
      if (areset) begin
        busy = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end else begin
        if (ar_hs) begin
          busy = 1'b1; beat = 0; cur_addr = sa; cur_burst = ar_cnt; ar_cnt++;
        end else if (r_hs) begin
          beat++;
          if (beat == 16) busy = 1'b0;
        end
        arready = !busy && (stall_en != 0 ? ($urandom_range(0, 3) != 0) : 1'b1);
        rvalid  = busy && (stall_en != 0 ? ($urandom_range(0, 2) != 0) : 1'b1);
        rdata   = mem_word(cur_addr + 32'(4 * beat));
        rlast   = busy && (beat == 15);
        rresp   = (busy && cur_burst == err_burst) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic start_frame(input logic f, input int eb);
    logic [31:0]  base;
    logic [511:0] seg;
    logic [1:0]   tag;
    bit           stop;
    int           g;
    int           n;
    base = f ? 32'h2BE00000 : 32'h2BC00000;
    err_burst = eb;
    ar_cnt = 0;
    stop = 0;
    for (int p = 0; p < NP; p++) begin
      if (!stop) begin
        exp_q.push_back({2'b10, 6'b0, 48'hadadadadadad, 48'hacacacacacac, 16'h9000,
                         16'(p), f, 383'b0});
        for (int b = 0; b < PB; b++) begin
          if (!stop) begin
            g = p * PB + b;
            for (int k = 0; k < 16; k++)
              seg[32*k +: 32] = mem_word(base + 32'(64 * g) + 32'(4 * k));
            tag = (b == PB - 1) ? 2'b01 : 2'b00;
`ifdef FRAME_PKT_READER_ERR_ABORT_EN
            if (g == eb) begin
              tag = 2'b01;
              stop = 1;
            end
`endif
            exp_q.push_back({tag, 6'b0, seg});
            exp_ar_q.push_back(base + 32'(64 * g));
          end
        end
      end
    end
    @(negedge clk);
    start_valid = 1'b1;
    flag = f;
    for (n = 0; n < 100 && !start_ready; n++) @(negedge clk);
    check(start_ready === 1'b1, "start_ready", 520'(start_ready), 520'(1));
    @(negedge clk);
    start_valid = 1'b0;
    flag = ~f;
  endtask

  task automatic wait_finish(input logic exp_fin);
    int  n;
    bit  held;
    for (n = 0; n < 30000 && !finish_valid; n++) @(negedge clk);
    check(finish_valid === 1'b1, "finish_valid_timeout", 520'(finish_valid), 520'(1));
    check(finish === exp_fin, "finish_value", 520'(finish), 520'(exp_fin));
    check(exp_q.size() == 0 && exp_ar_q.size() == 0, "scoreboard_drained",
          520'(exp_q.size() + exp_ar_q.size()), '0);
    held = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!(finish_valid && finish === exp_fin)) held = 0;
    end
    check(held, "finish_held", 520'(finish_valid), 520'(1));
    finish_ready = 1'b1;
    @(negedge clk);
    finish_ready = 1'b0;
    check(finish_valid === 1'b0, "finish_released", 520'(finish_valid), '0);
    exp_q.delete();
    exp_ar_q.delete();
  endtask

  initial begin
    logic [10:0] outs;
    int          tails;
    bit          viol;
    areset = 1'b1; start_valid = 1'b0; flag = 1'b0;
    finish_ready = 1'b0; pktout_alf = 1'b0;
    repeat (3) @(negedge clk);
    outs = {11{1'b1}};
    check({pktout_data, pktout_en, arvalid, rready, finish, finish_valid, start_ready} == '0,
          "reset_outputs", 520'({pktout_en, arvalid, rready, finish, finish_valid, start_ready}), '0);
    check({arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser} ==
          {1'b0, 8'd15, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 1'b1},
          "ar_constants",
          520'({arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser}),
          520'({1'b0, 8'd15, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 1'b1}));
    areset = 1'b0;

    // Full frame, even buffer, zero-wait slave.
    start_frame(1'b0, -1);
    wait_finish(1'b1);

    // Odd buffer with random AR/R stalls.
    stall_en = 1;
    start_frame(1'b1, -1);
    wait_finish(1'b1);

    // Almost-full held after the tail of packet 3.
    start_frame(1'b0, -1);
    tails = 0;
    for (int n = 0; n < 20000 && tails < 4; n++) begin
      @(negedge clk);
      if (pktout_en && pktout_data[519:518] == 2'b01) tails++;
    end
    check(tails == 4, "alf_tail3_seen", 520'(tails), 520'(4));
    pktout_alf = 1'b1;
    viol = 0;
    repeat (40) begin
      @(negedge clk);
      if (pktout_en || arvalid) viol = 1;
    end
    check(!viol, "alf_hold_quiet", 520'(viol), '0);
    pktout_alf = 1'b0;
    wait_finish(1'b1);

    // Error response on burst 5.
    stall_en = 0;
    start_frame(1'b0, 5);
    wait_finish(1'b0);
    err_burst = -1;

    // Reset mid-burst, then a clean frame from burst 0.
    start_frame(1'b0, -1);
    for (int n = 0; n < 2000 && !(rready && ar_cnt == 3); n++) @(negedge clk);
    check(rready === 1'b1, "mid_burst_reached", 520'(rready), 520'(1));
    @(posedge clk);
    #2;
    areset = 1'b1;
    #1;
    outs = {pktout_en, arvalid, rready, finish, finish_valid, start_ready, 5'b0};
    check({pktout_data, outs} == '0, "async_reset_outputs", 520'(outs), '0);
    @(negedge clk);
    check({pktout_data, pktout_en, arvalid, rready, finish, finish_valid, start_ready} == '0,
          "reset_held_outputs", 520'({pktout_en, arvalid, rready, start_ready}), '0);
    exp_q.delete();
    exp_ar_q.delete();
    repeat (2) @(negedge clk);
    areset = 1'b0;
    start_frame(1'b0, -1);
    wait_finish(1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
